// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit,
// each bit held for max(Prescale, 4) clock cycles.
module uart_tx_frame #(
  parameter int unsigned prescale_Width = 4,
  parameter int unsigned DATA_Width     = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [prescale_Width-1:0] Prescale,
  input  logic [DATA_Width-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int unsigned BitW = (DATA_Width > 1) ? $clog2(DATA_Width) : 1;
  localparam logic [prescale_Width-1:0] MinP = prescale_Width'(4);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_Width - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                    state_q;
  logic [prescale_Width-1:0] cnt_q;
  logic [prescale_Width-1:0] p_q;
  logic [BitW-1:0]           bit_q;
  logic [DATA_Width-1:0]     shr_q;
  logic                      par_en_q;
  logic                      par_bit_q;
  logic                      tx_q;
  logic                      busy_q;
  logic                      last_edge;

  assign last_edge = (cnt_q == p_q - prescale_Width'(1));
  assign TX_OUT    = tx_q;
  assign Busy      = busy_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      p_q       <= '0;
      bit_q     <= '0;
      shr_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else if (state_q == StIdle) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      if (DATA_VALID) begin
        // Everything the frame needs is captured here; later input changes are ignored.
        shr_q     <= P_DATA;
        par_en_q  <= PAR_EN;
        par_bit_q <= (^P_DATA) ^ PAR_TYP;
        p_q       <= (Prescale < MinP) ? MinP : Prescale;
        cnt_q     <= '0;
        bit_q     <= '0;
        tx_q      <= 1'b0;
        busy_q    <= 1'b1;
        state_q   <= StStart;
      end
    end else if (!last_edge) begin
      cnt_q <= cnt_q + prescale_Width'(1);
    end else begin
      cnt_q <= '0;
      unique case (state_q)
        StStart: begin
          state_q <= StData;
          tx_q    <= shr_q[0];
          shr_q   <= shr_q >> 1;
        end
        StData: begin
          if (bit_q == LastBit) begin
            state_q <= par_en_q ? StParity : StStop;
            tx_q    <= par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_q <= bit_q + BitW'(1);
            tx_q  <= shr_q[0];
            shr_q <= shr_q >> 1;
          end
        end
        StParity: begin
          state_q <= StStop;
          tx_q    <= 1'b1;
        end
        StStop: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: every frame is compared cycle by cycle
// against a line waveform built from the frame format.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] Prescale = 4'd8;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       Busy;

  int n_checks = 0;
  int n_fails  = 0;

  uart_tx_frame #(
    .prescale_Width(4),
    .DATA_Width(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Prescale(Prescale),
    .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .TX_OUT(TX_OUT),
    .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      n_fails++;
      $display("FAIL %s: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=0", name, TX_OUT, Busy);
    end
  endtask

  // Sends one frame and checks every line cycle against the model.
  // disturb: scramble inputs mid-frame and pulse DATA_VALID with 0x3C at cycle 20.
  task automatic run_frame(input string name, input logic [7:0] data, input logic pe,
                           input logic pt, input logic [3:0] presc, input bit disturb,
                           input bit keep_valid);
    logic bits[$];
    int   p;
    int   len;
    logic exp_tx;
    p = (presc < 4) ? 4 : int'(presc);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (pe) bits.push_back((^data) ^ pt);
    bits.push_back(1'b1);
    len = bits.size() * p;

    P_DATA = data; PAR_EN = pe; PAR_TYP = pt; Prescale = presc; DATA_VALID = 1'b1;
    tick();
    if (!keep_valid) DATA_VALID = 1'b0;
    for (int k = 0; k < len; k++) begin
      exp_tx = bits[k / p];
      n_checks++;
      if (TX_OUT !== exp_tx || Busy !== 1'b1) begin
        n_fails++;
        $display("FAIL %s cycle %0d: TX_OUT=%b Busy=%b, required TX_OUT=%b Busy=1",
                 name, k, TX_OUT, Busy, exp_tx);
      end
      if (disturb) begin
        Prescale = 4'd12;
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
        P_DATA   = (k == 20) ? 8'h3C : 8'($urandom);
        DATA_VALID = (k == 20);
      end
      tick();
    end
    if (!keep_valid) DATA_VALID = 1'b0;
    check_idle({name, " gap"});
  endtask

  task automatic test_reset();
    RST = 1'b1; DATA_VALID = 1'b1; P_DATA = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("reset held");
    end
    RST = 1'b0; DATA_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("after reset");
    end
  endtask

  task automatic test_parity();
    run_frame("a5 even", 8'hA5, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0);
    run_frame("a5 odd", 8'hA5, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0);
    run_frame("00 nopar", 8'h00, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
  endtask

  task automatic test_clamp();
    run_frame("clamp ff", 8'hFF, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
    run_frame("clamp 0", 8'h96, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_busy();
    run_frame("ignore 3c", 8'h81, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0);
    tick();
    check_idle("no queued frame");
  endtask

  task automatic test_back_to_back();
    run_frame("b2b 0", 8'h12, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1);
    run_frame("b2b 1", 8'hE7, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1);
    run_frame("b2b 2", 8'h3D, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 4'd5; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    // Start bit is 5 cycles, bits 0..2 another 15; land inside data bit 3.
    for (int i = 0; i < 22; i++) tick();
    n_checks++;
    if (Busy !== 1'b1 || TX_OUT !== 1'b1) begin
      n_fails++;
      $display("FAIL mid-frame bit3: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=1", TX_OUT, Busy);
    end
    RST = 1'b1;
    tick();
    check_idle("reset abort");
    RST = 1'b0;
    tick();
    check_idle("after abort");
    run_frame("post abort", 8'hC3, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_frame("random", 8'($urandom), 1'($urandom), 1'($urandom),
                4'($urandom_range(0, 15)), 1'($urandom), 1'b0);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_parity();
    test_clamp();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
